parity_checker_rx: RTL
======================

// Module: parity_checker_rx
// PURPOSE
//  Receive-side counterpart of the parity generator: checks each incoming frame against its parity bit.
//  A frame is DATA_W serial data bits, LSB first, followed by one parity bit.
//  Reassembles the data word, recomputes parity and compares it with the received bit.
//  Outputs the word with a valid pulse and an error flag, and keeps error statistics.
//  Sits between the serial link front-end and the byte consumer.
// PARAMETERS
//  DATA_W  8  data bits per frame (>=2)
//  ODD     0  0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data)
//  CNT_W   8  width of the saturating error counter
// PORTS
//  clk         in   1       rising-edge clock; sole clock
//  rst         in   1       synchronous reset, active-high
//  bit_valid   in   1       bit_in is valid this cycle
//  bit_in      in   1       serial data/parity bit
//  sof         in   1       start of frame; qualified by bit_valid; marks the first data bit
//  clr_stats   in   1       synchronous clear of err_count and err_sticky
//  data_out    out  DATA_W  last completed word; holds until next completion
//  data_valid  out  1       1-cycle pulse when data_out/parity_err update
//  parity_err  out  1       parity mismatch for the current data_out; holds with data_out
//  err_count   out  CNT_W   parity errors since reset/clear; saturates at all-ones
//  err_sticky  out  1       set on any parity error; cleared only by rst or clr_stats
//  busy        out  1       1 while in DATA or PARITY state
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; all outputs 0; the shift register and bit index are cleared.
//  Inputs are sampled only when bit_valid=1; cycles with bit_valid=0 do not advance the state (gaps allowed).
//  States:
//   IDLE: bit_valid&sof -> shift bit_in into position 0, idx=1, go to DATA.
//         bit_valid&!sof -> the bit is ignored.
//   DATA: each valid bit goes into position idx (LSB first) and idx increments.
//         After DATA_W bits, go to PARITY.
//         bit_valid&sof here = resync: the partial frame is discarded silently (no pulse, no error).
//         The sof bit becomes data bit 0 of a new frame and idx=1.
//   PARITY: on a valid bit, set exp = ^word ^ ODD.
//         parity_err <= (bit_in != exp); data_out <= word; data_valid <= 1 on the next cycle.
//         Then return to IDLE.
//         bit_valid&sof here: the bit is still treated as the parity bit; sof is ignored.
//  Latency: data_valid asserts on the cycle after the parity bit is sampled (registered).
//   Back-to-back: a sof on the cycle after the parity bit is accepted. IDLE is occupied for that one cycle.
//  Error statistics:
//   On each frame with parity_err=1: err_count += 1, saturating at 2^CNT_W-1; err_sticky <= 1.
//   clr_stats has priority over an increment in the same cycle: the result is count=0, sticky=0.
//   The simultaneous error is lost.
//   clr_stats does not affect the FSM, data_out or parity_err.
//  rst mid-frame: the frame is abandoned and no data_valid is generated.
//  busy = (state==DATA)|(state==PARITY); combinational from state.
// TESTING
//  T1 reset: hold rst 2 cycles mid-frame -> all outputs 0, state IDLE, no data_valid afterwards.
//  T2 even OK: sof + bits of 8'hA5 LSB first, parity=0 -> data_out=A5, data_valid 1 cycle, parity_err=0, err_count=0.
//  T3 even error: 8'h07 with parity=0 -> parity_err=1, err_count=1, err_sticky=1.
//     Then 8'h07 with parity=1 -> parity_err=0, count stays 1.
//  T4 gaps+resync: 8'h3C with random bit_valid gaps, sof reasserted after 5 bits, then a full 8'hFF frame with parity=0.
//     -> exactly one data_valid, data_out=FF, parity_err=0.
//  T5 saturation/clear (CNT_W=2): 5 bad frames -> err_count=3.
//     clr_stats coincident with the 6th bad frame's update -> count=0, sticky=0.
//  T6 ODD=1: 8'h00 with parity=1 -> err=0. 8'h01 with parity=1 -> err=1.
//     Back-to-back frames with no idle gap beyond the required 1 cycle -> both produce data_valid.

Source files
------------

// File: rtl/parity_checker_rx_if.sv
// -----------------------------------------------------------------------------
// parity_checker_rx_if
//   Bundles the serial-link side and the word/statistics side of the receive
//   parity checker so the checker and its surroundings connect through one port.
//
//   Link side (driven by master):
//     bit_valid  - bit_in/sof are meaningful this cycle
//     bit_in     - serial data or parity bit
//     sof        - first data bit of a frame (qualified by bit_valid)
//     clr_stats  - synchronous clear of err_count/err_sticky
//   Consumer side (driven by slave, the checker):
//     data_out   - last completed word, held until the next completion
//     data_valid - one-cycle pulse when data_out/parity_err update
//     parity_err - parity mismatch for the current data_out
//     err_count  - saturating count of parity errors
//     err_sticky - set on any parity error until rst/clr_stats
//     busy       - a frame is being received
// -----------------------------------------------------------------------------
interface parity_checker_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              bit_valid;
  logic              bit_in;
  logic              sof;
  logic              clr_stats;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic [CNT_W-1:0]  err_count;
  logic              err_sticky;
  logic              busy;

  // Link front-end / environment view.
  modport master (
    output bit_valid, bit_in, sof, clr_stats,
    input  data_out, data_valid, parity_err, err_count, err_sticky, busy
  );

  // Checker view.
  modport slave (
    input  bit_valid, bit_in, sof, clr_stats,
    output data_out, data_valid, parity_err, err_count, err_sticky, busy
  );
endinterface : parity_checker_rx_if

// File: rtl/parity_checker_rx.sv
// -----------------------------------------------------------------------------
// parity_checker_rx
//   Receive-side parity checker. A frame is DATA_W serial data bits (LSB first)
//   followed by one parity bit. The data word is reassembled, its parity is
//   recomputed and compared with the received parity bit. The word is presented
//   with a one-cycle valid pulse and an error flag; error statistics are kept.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous reset, active-high
//     bus  - parity_checker_rx_if.slave (link inputs, word and stats outputs)
//
//   Parameters:
//     DATA_W - data bits per frame (>= 2)
//     ODD    - 0: even parity (bit = ^data); 1: odd parity (bit = ~^data)
//     CNT_W  - width of the saturating error counter
// -----------------------------------------------------------------------------
module parity_checker_rx #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_checker_rx_if.slave    bus
);

  localparam int              IDX_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic            ODD_BIT  = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic [DATA_W-1:0] shift_q,      shift_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic [CNT_W-1:0]  err_count_q,  err_count_d;
  logic              err_sticky_q, err_sticky_d;

  logic              frame_done;
  logic              frame_bad;
  logic              exp_parity;

  // Expected parity bit of the word currently held in the shift register.
  assign exp_parity = (^shift_q) ^ ODD_BIT;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_done   = 1'b0;
    frame_bad    = 1'b0;

    if (bus.bit_valid) begin
      unique case (state_q)
        IDLE: begin
          // Non-sof bits between frames are dropped.
          if (bus.sof) begin
            shift_d    = '0;
            shift_d[0] = bus.bit_in;
            idx_d      = IDX_W'(1);
            state_d    = DATA;
          end
        end

        DATA: begin
          if (bus.sof) begin
            // Resync: the partial frame vanishes without a pulse or error,
            // and this bit starts the new frame.
            shift_d    = '0;
            shift_d[0] = bus.bit_in;
            idx_d      = IDX_W'(1);
          end else begin
            shift_d[idx_q] = bus.bit_in;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = PARITY;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          // sof is ignored here: the bit is always the parity bit.
          frame_done   = 1'b1;
          frame_bad    = (bus.bit_in != exp_parity);
          parity_err_d = frame_bad;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error statistics. A clear wins over a simultaneous error, which is lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (bus.clr_stats) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end else if (frame_done && frame_bad) begin
      err_sticky_d = 1'b1;
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is reset along with the control flops; it is a
    // handful of bits, and a clean restart keeps data_out predictable.
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.err_count  = err_count_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.busy       = (state_q == DATA) || (state_q == PARITY);

endmodule : parity_checker_rx
